// File: rtl/pow_pkg.sv
// Shared types for the integer power unit.
// Holds the FSM state encoding used by the top level.
package pow_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pow_sat_mul.sv
// One multiply step of the power loop with overflow detection.
// Saturation is sticky: a set ovf_in forces the maximum result.
module pow_sat_mul
    import pow_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RES_W  = 2 * DATA_W
) (
    input  logic [RES_W-1:0]  acc,
    input  logic [DATA_W-1:0] base,
    input  logic              ovf_in,
    output logic [RES_W-1:0]  acc_next,
    output logic              ovf_next
);

    localparam int PROD_W = RES_W + DATA_W;

    logic [PROD_W-1:0] prod;
    logic              hi;

    always_comb begin
        prod     = PROD_W'(acc) * PROD_W'(base);
        hi       = |prod[PROD_W-1:RES_W];
        ovf_next = ovf_in | hi;
        acc_next = ovf_next ? {RES_W{1'b1}} : prod[RES_W-1:0];
    end

endmodule

// File: rtl/pow_exp_unit.sv
// Handshaked integer power unit: data_i ** exp_i by repeated multiplication,
// saturating to the result width.
module pow_exp_unit
    import pow_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int EXP_W  = 4,
    parameter int RES_W  = 2 * DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [EXP_W-1:0]  exp_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [RES_W-1:0]  data_o,
    output logic              ovf_o
);

    state_t            state;
    logic [DATA_W-1:0] base;
    logic [EXP_W-1:0]  cnt;
    logic [RES_W-1:0]  acc;
    logic              ovf;
    logic [RES_W-1:0]  acc_next;
    logic              ovf_next;

    pow_sat_mul #(
        .DATA_W (DATA_W),
        .RES_W  (RES_W)
    ) u_mul (
        .acc      (acc),
        .base     (base),
        .ovf_in   (ovf),
        .acc_next (acc_next),
        .ovf_next (ovf_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            base  <= '0;
            cnt   <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (valid_i) begin
                        base  <= data_i;
                        cnt   <= exp_i;
                        acc   <= RES_W'(1);
                        ovf   <= 1'b0;
                        state <= (exp_i == '0) ? DONE : CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    ovf <= ovf_next;
                    cnt <= cnt - EXP_W'(1);
                    if (cnt == EXP_W'(1))
                        state <= DONE;
                end
                DONE: begin
                    if (ready_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; no input reaches them directly.
    assign ready_o = (state == IDLE);
    assign valid_o = (state == DONE);
    assign data_o  = acc;
    assign ovf_o   = ovf;

endmodule

// File: doc/pow_exp_unit.md
# pow_exp_unit

Parametrised, handshaked integer power unit. It computes data_i raised to a runtime exponent by repeated clocked multiplication and saturates to the result width. It generalises the fixed 8-bit squaring stage: configurable operand and result widths, a runtime exponent instead of a fixed power of 2, valid/ready flow control and an overflow flag. It sits in the arithmetic datapath wherever a squaring multiplier was previously instantiated; exp_i = 2 reproduces squaring.

## Interface

Parameters:
- DATA_W, 8: unsigned base width.
- EXP_W, 4: exponent width. Maximum exponent is 2^EXP_W − 1.
- RES_W, 2*DATA_W: result width. Must satisfy RES_W ≥ DATA_W.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  operand valid.
- ready_o  out  1  unit can accept an operand; high only in IDLE.
- data_i  in  DATA_W  unsigned base.
- exp_i  in  EXP_W  unsigned exponent.
- valid_o  out  1  result valid; held until accepted.
- ready_i  in  1  downstream accepts the result.
- data_o  out  RES_W  result, saturated to 2^RES_W − 1.
- ovf_o  out  1  saturation occurred in this operation; valid with valid_o.

## Operation

- **State machine:** states are IDLE, CALC and DONE.
- **Accept:** happens on an edge where state = IDLE and valid_i = 1.
  - Latch base ← data_i, cnt ← exp_i, acc ← 1, ovf ← 0.
  - Next state is DONE if exp_i = 0, otherwise CALC.
- **CALC:** each cycle computes the full product p = acc × base (RES_W + DATA_W bits).
  - If p[RES_W+DATA_W−1:RES_W] ≠ 0 or ovf = 1: acc ← all ones and ovf ← 1.
  - Otherwise acc ← p[RES_W−1:0].
  - cnt ← cnt − 1. When cnt = 1 this cycle, next state is DONE.
- **Saturation is sticky:** once ovf is set, acc stays at max for the rest of the operation.
- **DONE:**
  - valid_o = 1, data_o = acc, ovf_o = ovf.
  - On an edge with ready_i = 1 the unit returns to IDLE. Otherwise it holds with data_o and ovf_o stable.
- **Inputs outside IDLE:** valid_i, data_i and exp_i are ignored in CALC and DONE. Upstream must hold its operand until it sees ready_o.
- **No back-to-back accept:** there is no accept in the same cycle as the DONE→IDLE return, because ready_o is registered from state. Maximum throughput is one operation per (exp + 2) cycles.
- **Zero exponent:** 0^0 = 1 and x^0 = 1.
- **Zero base:** 0^e = 0 for e ≥ 1.

## Timing

- **Reset values:** state = IDLE, ready_o = 1, valid_o = 0, data_o = 0, ovf_o = 0, acc = 0, cnt = 0.
- **Latency:** with accept at edge k and exponent e ≥ 1:
  - CALC occupies the cycles after edges k+1 … k+e.
  - valid_o rises after edge k+e.
  - Accept-to-valid latency is e edges; for e = 0 it is 1 edge.
- **ready_o:** combinational decode of state == IDLE. No path from valid_i.
- **Output registers:** valid_o, data_o and ovf_o come from registered state, acc and ovf. There is no combinational path from inputs to outputs.
- **Reset mid-operation:** rst in CALC or DONE aborts within that edge. All outputs take their reset values and the in-flight result is discarded with no valid_o pulse.
- **Reset priority:** rst takes priority over a simultaneous accept or a simultaneous ready_i.
- **Multiplier path:** the single-cycle DATA_W × RES_W multiply is the critical path. No internal pipelining.

## Structure

- **Package pow_pkg:**
  - state enum {IDLE, CALC, DONE}.
  - Helper constant PROD_W = RES_W + DATA_W, computed in the module from the parameters.
- **Sub-module pow_sat_mul:**
  - Purely combinational.
  - Inputs: acc, base, ovf_in. Outputs: acc_next, ovf_next.
  - Implements the multiply, overflow detection and sticky saturation.
- **Top level:** pow_exp_unit holds the FSM, counter and registers.

## Test plan

All cases use defaults DATA_W = 8, EXP_W = 4, RES_W = 16.

1. **Basic power:** data_i = 3, exp_i = 4 with ready_i = 1 → data_o = 81, ovf_o = 0. valid_o rises 4 edges after accept, a 1-cycle pulse.
2. **Zero cases:**
   - 0^0 → data_o = 1 after 1 edge.
   - 0^5 → data_o = 0 after 5 edges.
   - 7^1 → data_o = 7 after 1 edge.
3. **Width boundary and overflow:**
   - 255^2 → 65025, ovf_o = 0.
   - 16^4 → 0xFFFF, ovf_o = 1.
   - 2^15 → 32768, ovf_o = 0.
   - 255^15 → 0xFFFF, ovf_o = 1.
4. **Backpressure:** ready_i held 0 for 10 cycles in DONE → valid_o, data_o and ovf_o stay stable. ready_o stays 0, and a new valid_i is not accepted until 1 cycle after ready_i = 1.
5. **Reset mid-CALC:** rst after 2 of 6 CALC cycles → next cycle ready_o = 1, valid_o = 0, data_o = 0. A new 2^3 afterwards returns 8.
6. **Randomised streaming:** 1000 random (data_i, exp_i) pairs with random valid_i and ready_i, checked against a saturating reference model:
   - every accepted operand produces exactly one result, in order;
   - no result is dropped or duplicated.
